uart_led_cmd_ctrl: RTL and testbench

//  Command controller between the UART byte receiver and the LED driver.

---
 rtl/uart_led_cmd_ctrl.sv | 121 ++++++++++++
 tb/tb_uart_led_cmd_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_led_cmd_ctrl.sv
// rtl/uart_led_cmd_ctrl.sv - UART command frame parser committing LED period/control words
// Frame: 55 A5 ADDR D3 D2 D1 D0 CTRL F0; repeated headers resync, stalled frames time out.
module uart_led_cmd_ctrl #(
   parameter logic [7:0]  DEV_ADDR     = 8'h01,
   parameter int          TIMEOUT_CYC  = 1_000_000,
   parameter logic [31:0] TIME_DEFAULT = 32'd24_999_999
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic [7:0]  Rx_Data,
   input  logic        Rx_Done,
   output logic [31:0] Time_Set,
   output logic [7:0]  Ctrl_Set,
   output logic        Cfg_Valid,
   output logic        Frame_Err,
   output logic        Busy
);

   localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

   typedef enum logic [3:0] {
      S_IDLE, S_HDR2, S_ADDR, S_D3, S_D2, S_D1, S_D0, S_CTRL, S_TAIL
   } state_t;

   state_t           state, state_next;
   logic [CNT_W-1:0] tmo_cnt;
   logic [7:0]       shadow_addr;
   logic [31:0]      shadow_data;
   logic [7:0]       shadow_ctrl;
   logic             tail_err;
   logic             timeout_hit;
   logic             addr_match;
   logic             tail_ok;

   // A byte arriving on the expiry cycle takes priority over the timeout.
   assign timeout_hit = (state != S_IDLE) && (tmo_cnt == TMO_LAST) && !Rx_Done;
   assign addr_match  = (shadow_addr == DEV_ADDR) || (shadow_addr == 8'hFF);
   assign tail_ok     = (Rx_Data == 8'hF0);

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      if (Rx_Done) begin
         unique case (state)
            S_IDLE:  state_next = (Rx_Data == 8'h55) ? S_HDR2 : S_IDLE;
            S_HDR2: begin
               if (Rx_Data == 8'hA5)      state_next = S_ADDR;
               else if (Rx_Data == 8'h55) state_next = S_HDR2;
               else                       state_next = S_IDLE;
            end
            S_ADDR:  state_next = S_D3;
            S_D3:    state_next = S_D2;
            S_D2:    state_next = S_D1;
            S_D1:    state_next = S_D0;
            S_D0:    state_next = S_CTRL;
            S_CTRL:  state_next = S_TAIL;
            S_TAIL:  state_next = S_IDLE;
            default: state_next = S_IDLE;
         endcase
      end else if (timeout_hit) begin
         state_next = S_IDLE;
      end
   end

   always_comb begin
      Busy      = (state != S_IDLE);
      Frame_Err = tail_err | timeout_hit;
   end

   always_ff @(posedge Clk) begin
      if (Reset || state == S_IDLE || Rx_Done || timeout_hit) begin
         tmo_cnt <= '0;
      end else begin
         tmo_cnt <= tmo_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         shadow_addr <= '0;
         shadow_data <= '0;
         shadow_ctrl <= '0;
         Time_Set    <= TIME_DEFAULT;
         Ctrl_Set    <= '0;
         Cfg_Valid   <= 1'b0;
         tail_err    <= 1'b0;
      end else begin
         Cfg_Valid <= 1'b0;
         tail_err  <= 1'b0;
         if (Rx_Done) begin
            unique case (state)
               S_ADDR: shadow_addr        <= Rx_Data;
               S_D3:   shadow_data[31:24] <= Rx_Data;
               S_D2:   shadow_data[23:16] <= Rx_Data;
               S_D1:   shadow_data[15:8]  <= Rx_Data;
               S_D0:   shadow_data[7:0]   <= Rx_Data;
               S_CTRL: shadow_ctrl        <= Rx_Data;
               S_TAIL: begin
                  if (!tail_ok) begin
                     tail_err <= 1'b1;
                  end else if (addr_match) begin
                     Time_Set  <= shadow_data;
                     Ctrl_Set  <= shadow_ctrl;
                     Cfg_Valid <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_led_cmd_ctrl.sv
// tb/tb_uart_led_cmd_ctrl.sv - directed-vector bench for uart_led_cmd_ctrl
module tb_uart_led_cmd_ctrl;

   localparam logic [31:0] TDEF = 32'd24_999_999;

   typedef logic [7:0] byte_q_t[$];

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic [7:0]  Rx_Data = 8'h00;
   logic        Rx_Done = 1'b0;
   logic [31:0] Time_Set;
   logic [7:0]  Ctrl_Set;
   logic        Cfg_Valid;
   logic        Frame_Err;
   logic        Busy;

   int n_vec = 0;
   int n_err = 0;
   int cfg_cnt = 0;
   int err_cnt = 0;
   int both_cnt = 0;

   uart_led_cmd_ctrl #(
      .DEV_ADDR    (8'h01),
      .TIMEOUT_CYC (64),
      .TIME_DEFAULT(TDEF)
   ) dut (
      .Clk      (Clk),
      .Reset    (Reset),
      .Rx_Data  (Rx_Data),
      .Rx_Done  (Rx_Done),
      .Time_Set (Time_Set),
      .Ctrl_Set (Ctrl_Set),
      .Cfg_Valid(Cfg_Valid),
      .Frame_Err(Frame_Err),
      .Busy     (Busy)
   );

   always #5 Clk = ~Clk;

   // Pulse-cycle counters: a one-cycle pulse adds exactly one.
   always @(negedge Clk) begin
      if (Cfg_Valid) cfg_cnt++;
      if (Frame_Err) err_cnt++;
      if (Cfg_Valid && Frame_Err) both_cnt++;
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(posedge Clk); #1;
      Rx_Data = b;
      Rx_Done = 1'b1;
      @(posedge Clk); #1;
      Rx_Done = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge Clk); #1;
      end
   endtask

   // Returns one step after the edge that sampled the last byte.
   task automatic send_seq(input byte_q_t q, input int gap);
      for (int i = 0; i < q.size(); i++) begin
         send_byte(q[i]);
         if (i != q.size() - 1) idle(gap);
      end
   endtask

   int c0, e0;
   int hit_at;

   initial begin
      // 1: reset and idle
      idle(3);
      Reset = 1'b0;
      c0 = cfg_cnt; e0 = err_cnt;
      idle(100);
      check_val("rst_time", Time_Set, TDEF);
      check_val("rst_ctrl", {24'h0, Ctrl_Set}, 32'h0);
      check_val("rst_busy", {31'h0, Busy}, 32'h0);
      check_val("rst_pulses", cfg_cnt + err_cnt - c0 - e0, 0);

      // 2: basic frame, latency one cycle after tail strobe
      c0 = cfg_cnt;
      send_seq('{8'h55, 8'hA5, 8'h01, 8'h00, 8'h98, 8'h96}, 50);
      idle(50);
      check_val("mid_busy", {31'h0, Busy}, 32'h1);
      send_seq('{8'h7F, 8'h03, 8'hF0}, 50);
      check_val("t2_valid", {31'h0, Cfg_Valid}, 32'h1);
      check_val("t2_time", Time_Set, 32'h0098967F);
      check_val("t2_ctrl", {24'h0, Ctrl_Set}, 32'h03);
      idle(5);
      check_val("t2_pulses", cfg_cnt - c0, 1);
      check_val("t2_busy", {31'h0, Busy}, 32'h0);

      // 3: broadcast accepted, foreign address dropped
      c0 = cfg_cnt; e0 = err_cnt;
      send_seq('{8'h55, 8'hA5, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h10, 8'hAA, 8'hF0}, 3);
      idle(3);
      check_val("t3_bc_time", Time_Set, 32'h10);
      check_val("t3_bc_ctrl", {24'h0, Ctrl_Set}, 32'hAA);
      send_seq('{8'h55, 8'hA5, 8'h07, 8'h00, 8'h00, 8'h00, 8'h99, 8'h11, 8'hF0}, 3);
      idle(3);
      check_val("t3_na_time", Time_Set, 32'h10);
      check_val("t3_na_ctrl", {24'h0, Ctrl_Set}, 32'hAA);
      check_val("t3_cfg_cnt", cfg_cnt - c0, 1);
      check_val("t3_err_cnt", err_cnt - e0, 0);

      // 4: repeated header resync, then bad tail
      c0 = cfg_cnt; e0 = err_cnt;
      send_seq('{8'h55, 8'h55, 8'h55, 8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h20, 8'h01, 8'hF0}, 2);
      idle(3);
      check_val("t4_time", Time_Set, 32'h20);
      check_val("t4_ctrl", {24'h0, Ctrl_Set}, 32'h01);
      send_seq('{8'h55, 8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h30, 8'h02, 8'h0F}, 2);
      check_val("t4_ferr", {31'h0, Frame_Err}, 32'h1);
      idle(3);
      check_val("t4_hold_time", Time_Set, 32'h20);
      check_val("t4_hold_ctrl", {24'h0, Ctrl_Set}, 32'h01);
      check_val("t4_err_cnt", err_cnt - e0, 1);
      check_val("t4_cfg_cnt", cfg_cnt - c0, 1);

      // 5: stall timeout 63 cycles after last strobe
      e0 = err_cnt;
      send_seq('{8'h55, 8'hA5, 8'h01, 8'h00}, 1);
      hit_at = 0;
      for (int i = 1; i <= 100; i++) begin
         @(posedge Clk); #1;
         if (Frame_Err) begin
            hit_at = i;
            break;
         end
      end
      check_val("t5_tmo_cycle", hit_at, 63);
      idle(1);
      check_val("t5_busy", {31'h0, Busy}, 32'h0);
      check_val("t5_err_cnt", err_cnt - e0, 1);
      c0 = cfg_cnt;
      send_seq('{8'h55, 8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h21, 8'h04, 8'hF0}, 10);
      idle(2);
      check_val("t5_after_time", Time_Set, 32'h21);
      check_val("t5_after_cfg", cfg_cnt - c0, 1);

      // 5b: byte lands on the expiry cycle
      e0 = err_cnt;
      send_seq('{8'h55, 8'hA5, 8'h01, 8'h00}, 1);
      idle(63);
      Rx_Data = 8'h00;
      Rx_Done = 1'b1;
      #1;
      check_val("t5b_no_ferr", {31'h0, Frame_Err}, 32'h0);
      @(posedge Clk); #1;
      Rx_Done = 1'b0;
      check_val("t5b_busy", {31'h0, Busy}, 32'h1);
      send_seq('{8'h00, 8'h40, 8'h05, 8'hF0}, 5);
      idle(2);
      check_val("t5b_time", Time_Set, 32'h40);
      check_val("t5b_ctrl", {24'h0, Ctrl_Set}, 32'h05);
      check_val("t5b_err_cnt", err_cnt - e0, 0);

      // 6: reset mid-frame
      c0 = cfg_cnt; e0 = err_cnt;
      send_seq('{8'h55, 8'hA5, 8'h01, 8'h00, 8'h11}, 2);
      @(posedge Clk); #1;
      Reset = 1'b1;
      @(posedge Clk); #1;
      Reset = 1'b0;
      check_val("t6_busy", {31'h0, Busy}, 32'h0);
      check_val("t6_time", Time_Set, TDEF);
      check_val("t6_ctrl", {24'h0, Ctrl_Set}, 32'h0);
      idle(5);
      check_val("t6_pulses", cfg_cnt + err_cnt - c0 - e0, 0);
      send_seq('{8'h55, 8'hA5, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9C, 8'hF0}, 2);
      check_val("t6_valid", {31'h0, Cfg_Valid}, 32'h1);
      check_val("t6_new_time", Time_Set, 32'h12345678);
      check_val("t6_new_ctrl", {24'h0, Ctrl_Set}, 32'h9C);

      // back-to-back: header right after commit
      send_byte(8'h55);
      check_val("b2b_busy", {31'h0, Busy}, 32'h1);
      send_seq('{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h77, 8'h08, 8'hF0}, 0);
      idle(2);
      check_val("b2b_time", Time_Set, 32'h77);
      check_val("no_overlap", both_cnt, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
